// File: rtl/bep_frame_decoder.sv
// ---------------------------------------------------------------------------
// bep_frame_decoder
//
// Parametrised serial frame receiver. It slides a PREAMBLE_BITS-wide window
// over the accepted bit stream looking for PREAMBLE. It then collects the
// remaining FRAME_BITS-PREAMBLE_BITS payload bits and presents the complete
// frame on a parallel register with a one-cycle strobe. Reception is
// abandoned with a one-cycle abort strobe when the idle gap between accepted
// bits reaches GAP_LIMIT cycles.
//
// Optional feature (compile-time macro BEP_FRAME_CHECKSUM_EN):
//   defined   - the payload is read as MSB-first bytes. frame_error is set
//               when the mod-256 sum of all payload bytes except the last
//               differs from the last byte. The sum is built one byte at a
//               time while the payload arrives.
//   undefined - frame_error is tied low and no accumulator is built.
//
// Parameters:
//   FRAME_BITS    total frame length including the preamble
//   PREAMBLE_BITS preamble length
//   PREAMBLE      preamble pattern, MSB received first
//   GAP_LIMIT     idle cycles between accepted bits that abort a reception
//
// Ports:
//   serial_clock  in   sole clock, rising edge
//   reset         in   asynchronous, active-high
//   serial_data   in   bit value, sampled when serial_valid=1
//   serial_valid  in   bit qualifier, one bit per qualified cycle
//   frame         out  last completed frame, first bit at the MSB
//   frame_valid   out  one-cycle strobe, frame updated this cycle
//   frame_error   out  checksum mismatch, meaningful with frame_valid
//   frame_abort   out  one-cycle strobe, gap timeout abandoned a frame
//   busy          out  high while receiving the payload
// ---------------------------------------------------------------------------
module bep_frame_decoder #(
    parameter int                       FRAME_BITS    = 192,
    parameter int                       PREAMBLE_BITS = 32,
    parameter logic [PREAMBLE_BITS-1:0] PREAMBLE      = 32'hAAAA_AAAA,
    parameter int                       GAP_LIMIT     = 64
) (
    input  logic                  serial_clock,
    input  logic                  reset,
    input  logic                  serial_data,
    input  logic                  serial_valid,
    output logic [FRAME_BITS-1:0] frame,
    output logic                  frame_valid,
    output logic                  frame_error,
    output logic                  frame_abort,
    output logic                  busy
);

    localparam int P   = FRAME_BITS - PREAMBLE_BITS;
    localparam int BCW = $clog2(P);
    localparam int GW  = $clog2(GAP_LIMIT + 1);

    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

`ifdef BEP_FRAME_CHECKSUM_EN
    function automatic logic [7:0] add_mod256(input logic [7:0] a,
                                              input logic [7:0] b);
        return a + b;
    endfunction
`endif

    logic [0:0]               r_state;
    logic [PREAMBLE_BITS-1:0] r_hunt;
    // Only P-1 payload bits need storing: the final bit is taken straight
    // from serial_data on the completion edge.
    logic [P-2:0]             r_payload;
    logic [BCW-1:0]           r_bitcnt;
    logic [GW-1:0]            r_gapcnt;
    logic [FRAME_BITS-1:0]    r_frame;
    logic                     r_frame_valid;
    logic                     r_frame_abort;

    logic [PREAMBLE_BITS:0]   w_hunt_cat;
    logic [PREAMBLE_BITS-1:0] w_hunt_shift;
    logic                     w_pre_match;
    logic                     w_last_bit;
    logic [GW-1:0]            w_gap_inc;
    logic                     w_gap_hit;

    // The concatenation keeps the shift legal for a one-bit preamble.
    assign w_hunt_cat   = {r_hunt, serial_data};
    assign w_hunt_shift = w_hunt_cat[PREAMBLE_BITS-1:0];
    assign w_pre_match  = (w_hunt_shift == PREAMBLE);
    assign w_last_bit   = (r_bitcnt == BCW'(P - 1));
    assign w_gap_inc    = r_gapcnt + GW'(1);
    assign w_gap_hit    = (w_gap_inc == GW'(GAP_LIMIT));

`ifdef BEP_FRAME_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       r_frame_error;
    logic [7:0] w_byte;
    logic       w_byte_done;

    // Byte formed by the seven newest stored bits plus the bit arriving now.
    assign w_byte      = {r_payload[6:0], serial_data};
    assign w_byte_done = (r_bitcnt[2:0] == 3'b111);

    always_ff @(posedge serial_clock or posedge reset) begin
        if (reset) begin
            r_csum        <= 8'd0;
            r_frame_error <= 1'b0;
        end else begin
            r_frame_error <= 1'b0;
            if (r_state == ST_HUNT) begin
                if (serial_valid && w_pre_match) begin
                    r_csum <= 8'd0;
                end
            end else if (serial_valid) begin
                if (w_last_bit) begin
                    // The completing byte is the checksum byte itself.
                    r_frame_error <= (r_csum != w_byte);
                end else if (w_byte_done) begin
                    r_csum <= add_mod256(r_csum, w_byte);
                end
            end
        end
    end

    assign frame_error = r_frame_error;
`else
    assign frame_error = 1'b0;
`endif

    always_ff @(posedge serial_clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_HUNT;
            r_hunt        <= '0;
            r_payload     <= '0;
            r_bitcnt      <= '0;
            r_gapcnt      <= '0;
            r_frame       <= '0;
            r_frame_valid <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_frame_abort <= 1'b0;
            if (r_state == ST_HUNT) begin
                if (serial_valid) begin
                    r_hunt <= w_hunt_shift;
                    if (w_pre_match) begin
                        r_state  <= ST_RECV;
                        r_bitcnt <= '0;
                        r_gapcnt <= '0;
                    end
                end
            end else begin
                if (serial_valid) begin
                    // An accepted bit always wins over a gap that would
                    // expire on the same cycle.
                    r_gapcnt <= '0;
                    if (w_last_bit) begin
                        r_frame       <= {PREAMBLE, r_payload, serial_data};
                        r_frame_valid <= 1'b1;
                        r_hunt        <= '0;
                        r_bitcnt      <= '0;
                        r_state       <= ST_HUNT;
                    end else begin
                        r_payload <= {r_payload[P-3:0], serial_data};
                        r_bitcnt  <= r_bitcnt + BCW'(1);
                    end
                end else if (w_gap_hit) begin
                    r_frame_abort <= 1'b1;
                    r_hunt        <= '0;
                    r_gapcnt      <= '0;
                    r_bitcnt      <= '0;
                    r_state       <= ST_HUNT;
                end else begin
                    r_gapcnt <= w_gap_inc;
                end
            end
        end
    end

    assign frame       = r_frame;
    assign frame_valid = r_frame_valid;
    assign frame_abort = r_frame_abort;
    assign busy        = (r_state == ST_RECV);

endmodule

// File: tb/tb_bep_frame_decoder.sv
// Bench for bep_frame_decoder: a default-parameter instance driven from a
// table of frame scenarios plus hand-written sequences, and a small
// 40-bit instance driven with a throttled bit stream.
module tb_bep_frame_decoder;

    localparam logic [31:0] PRE0 = 32'hAAAA_AAAA;
    localparam logic [7:0]  PRE1 = 8'hD5;
    localparam int          GAP  = 64;

    typedef struct {
        logic [191:0] frame;
        logic         err;
    } exp_t;

    typedef struct {
        int          junk_len;
        logic [15:0] junk;
        int          early;
        int          stall_at;
        int          stall_len;
        bit          corrupt;
        bit          exp_abort;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         s0_data, s0_valid, s1_data, s1_valid;
    logic [191:0] frame0;
    logic         fv0, fe0, fa0, busy0;
    logic [39:0]  frame1;
    logic         fv1, fe1, fa1, busy1;

    int   n_checks, n_fail, n_abort0;
    exp_t q0[$];
    exp_t q1[$];
    logic [191:0] last_exp0;

    bep_frame_decoder dut0 (
        .serial_clock(clk), .reset(reset),
        .serial_data(s0_data), .serial_valid(s0_valid),
        .frame(frame0), .frame_valid(fv0), .frame_error(fe0),
        .frame_abort(fa0), .busy(busy0)
    );

    bep_frame_decoder #(
        .FRAME_BITS(40), .PREAMBLE_BITS(8), .PREAMBLE(8'hD5), .GAP_LIMIT(64)
    ) dut1 (
        .serial_clock(clk), .reset(reset),
        .serial_data(s1_data), .serial_valid(s1_valid),
        .frame(frame1), .frame_valid(fv1), .frame_error(fe1),
        .frame_abort(fa1), .busy(busy1)
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [159:0] make_pl(input int nbytes);
        logic [159:0] r;
        logic [7:0]   s;
        logic [7:0]   b;
        r = '0;
        s = 8'd0;
        for (int i = nbytes - 1; i >= 1; i--) begin
            b = 8'($urandom);
            r[i*8 +: 8] = b;
            s = s + b;
        end
        r[7:0] = s;
        return r;
    endfunction

    function automatic logic chk_err(input logic [159:0] pl, input int nbytes);
        logic [7:0] s;
        s = 8'd0;
`ifdef BEP_FRAME_CHECKSUM_EN
        for (int i = nbytes - 1; i >= 1; i--) s = s + pl[i*8 +: 8];
        return (s != pl[7:0]);
`else
        if (nbytes < 0) s = pl[7:0];
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_bit0(input logic b);
        s0_valid = 1'b1;
        s0_data  = b;
        tick();
        s0_valid = 1'b0;
        s0_data  = 1'b0;
    endtask

    task automatic idle0();
        s0_valid = 1'b0;
        tick();
    endtask

    // Scoreboard for the default instance.
    always @(negedge clk) begin
        if (!reset) begin
            if (fa0) n_abort0++;
            if (fv0) begin
                if (q0.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame0: actual=%h required=no frame", frame0);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    chkw("frame0", frame0, e.frame);
                    chk1("frame_error0", fe0, e.err);
                    chk1("busy_at_done0", busy0, 1'b0);
                end
            end
        end
    end

    // Scoreboard for the 40-bit instance.
    always @(negedge clk) begin
        if (!reset) begin
            if (fa1) chk1("abort1", fa1, 1'b0);
            if (fv1) begin
                if (q1.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame1: actual=%h required=no frame", frame1);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    chkw("frame1", 192'(frame1), e.frame);
                    chk1("frame_error1", fe1, e.err);
                end
            end
        end
    end

    task automatic run_case(input int id, input vec_t v);
        logic [159:0] pl, dpl;
        logic [191:0] cat;
        exp_t e;
        pl = make_pl(20);
        if (v.corrupt) pl[7:0] = pl[7:0] + 8'd1;
        // When the preamble is matched early, its tail bits become payload.
        cat = {PRE0, pl};
        dpl = cat[v.early +: 160];
        e.frame = {PRE0, dpl};
        e.err   = chk_err(dpl, 20);
        send_bit0(1'b1);
        for (int i = v.junk_len - 1; i >= 0; i--) send_bit0(v.junk[i]);
        for (int i = 31; i >= 0; i--) send_bit0(PRE0[i]);
        chk1($sformatf("case%0d_busy_after_preamble", id), busy0, 1'b1);
        if (!v.exp_abort) q0.push_back(e);
        for (int j = 159; j >= v.early; j--) begin
            if (v.stall_len > 0 && j == 159 - v.stall_at) begin
                for (int k = 0; k < v.stall_len; k++) begin
                    idle0();
                    chk1($sformatf("case%0d_abort_idle%0d", id, k), fa0, (k == GAP - 1));
                    chk1($sformatf("case%0d_busy_idle%0d", id, k), busy0, (k < GAP - 1));
                end
                if (v.exp_abort) begin
                    chkw($sformatf("case%0d_frame_kept", id), frame0, last_exp0);
                    chk1($sformatf("case%0d_busy_after_abort", id), busy0, 1'b0);
                    idle0();
                    chk1($sformatf("case%0d_abort_one_cycle", id), fa0, 1'b0);
                    return;
                end
            end
            send_bit0(pl[j]);
        end
        chk1($sformatf("case%0d_latency", id), fv0, 1'b1);
        last_exp0 = e.frame;
        idle0();
        chk1($sformatf("case%0d_strobe_one_cycle", id), fv0, 1'b0);
    endtask

    vec_t tbl[6];

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  pl1;
        logic [39:0]  fr1;
        logic [159:0] pl50;
        exp_t         e1;
        n_checks  = 0;
        n_fail    = 0;
        n_abort0  = 0;
        last_exp0 = '0;
        reset     = 1'b1;
        s0_data   = 1'b0;
        s0_valid  = 1'b0;
        s1_data   = 1'b0;
        s1_valid  = 1'b0;
        repeat (3) @(negedge clk);
        chkw("reset_frame0", frame0, '0);
        chk1("reset_fv0", fv0, 1'b0);
        chk1("reset_fe0", fe0, 1'b0);
        chk1("reset_fa0", fa0, 1'b0);
        chk1("reset_busy0", busy0, 1'b0);
        chkw("reset_frame1", 192'(frame1), '0);
        chk1("reset_busy1", busy1, 1'b0);
        reset = 1'b0;

        //            junk_len junk     early stall_at len corrupt abort
        tbl[0] = '{0, 16'h0000, 0, -1,  0,  1'b0, 1'b0}; // nominal
        tbl[1] = '{9, 16'h0166, 2, -1,  0,  1'b0, 1'b0}; // junk + extra 10 pair
        tbl[2] = '{0, 16'h0000, 0, 80,  63, 1'b0, 1'b0}; // gap just below limit
        tbl[3] = '{0, 16'h0000, 0, -1,  0,  1'b1, 1'b0}; // checksum byte +1
        tbl[4] = '{0, 16'h0000, 0, 100, 64, 1'b0, 1'b1}; // gap timeout
        tbl[5] = '{0, 16'h0000, 0, -1,  0,  1'b0, 1'b0}; // recovery
        for (int i = 0; i < 6; i++) run_case(i, tbl[i]);

        // 31 preamble bits then a wrong final bit: never enters RECEIVE.
        send_bit0(1'b1);
        for (int i = 31; i >= 1; i--) begin
            send_bit0(PRE0[i]);
            chk1("near_miss_busy", busy0, 1'b0);
        end
        send_bit0(~PRE0[0]);
        chk1("near_miss_final_busy", busy0, 1'b0);
        idle0();

        // Reset asserted at payload bit 50 discards everything at once.
        pl50 = make_pl(20);
        send_bit0(1'b1);
        for (int i = 31; i >= 0; i--) send_bit0(PRE0[i]);
        for (int j = 159; j > 109; j--) send_bit0(pl50[j]);
        chk1("midframe_busy", busy0, 1'b1);
        #2 reset = 1'b1;
        #1;
        chkw("async_reset_frame0", frame0, '0);
        chk1("async_reset_fv0", fv0, 1'b0);
        chk1("async_reset_fe0", fe0, 1'b0);
        chk1("async_reset_fa0", fa0, 1'b0);
        chk1("async_reset_busy0", busy0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        last_exp0 = '0;
        run_case(6, tbl[0]);

        // 40-bit instance, one accepted bit every third cycle.
        pl1 = 32'(make_pl(4));
        fr1 = {PRE1, pl1};
        e1.frame = 192'(fr1);
        e1.err   = chk_err(160'(pl1), 4);
        for (int k = 39; k >= 0; k--) begin
            int  idx;
            bit  expb;
            idx  = 39 - k;
            expb = (idx >= 7) && (idx < 39);
            if (idx == 39) q1.push_back(e1);
            s1_valid = 1'b1;
            s1_data  = fr1[k];
            tick();
            s1_valid = 1'b0;
            s1_data  = 1'b0;
            chk1($sformatf("thr_busy_bit%0d", idx), busy1, expb);
            if (idx == 39) chk1("thr_latency", fv1, 1'b1);
            tick();
            chk1($sformatf("thr_busy_gap%0d", idx), busy1, expb);
            if (idx == 39) chk1("thr_strobe_one_cycle", fv1, 1'b0);
            tick();
        end
        chkw("thr_frame_held", 192'(frame1), 192'(fr1));

        repeat (2) tick();
        chkw("abort_count0", 192'(n_abort0), 192'(1));
        chkw("scoreboard0_drained", 192'(q0.size()), '0);
        chkw("scoreboard1_drained", 192'(q1.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bep_frame_decoder.md
# bep_frame_decoder

Parametrised serial frame receiver. It is the next-generation replacement for the fixed-layout thermostat serial decoder.

- Hunts for a configurable preamble in a gated serial bit stream, then collects a fixed-length frame.
- On completion, presents the whole frame on a parallel output register with a one-cycle strobe.
- Also provides inter-bit gap timeout, abort reporting and optional byte-checksum validation.
- Sits between the tile's input pins and the field-extraction and display logic in the top level.

## Interface

Parameters:

- FRAME_BITS, 192: total frame length in bits, preamble included; (FRAME_BITS − PREAMBLE_BITS) must be a multiple of 8 and ≥ 16.
- PREAMBLE_BITS, 32: preamble length, 1..FRAME_BITS−16.
- PREAMBLE, 32'hAAAA_AAAA: preamble pattern; MSB is received first.
- GAP_LIMIT, 64: maximum idle serial_clock cycles between accepted bits while receiving; must be ≥ 1.

Ports:

- serial_clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- serial_data  in  1  bit value, sampled only when serial_valid=1.
- serial_valid  in  1  bit qualifier; exactly one bit is accepted per cycle with serial_valid=1.
- frame  out  FRAME_BITS  last completed frame; first received bit is at frame[FRAME_BITS-1].
- frame_valid  out  1  one-cycle strobe; frame was updated on this cycle.
- frame_error  out  1  checksum mismatch; valid only while frame_valid=1.
- frame_abort  out  1  one-cycle strobe; reception was abandoned on a gap timeout.
- busy  out  1  high in RECEIVE.

## Operation

The block has two states, HUNT and RECEIVE. Reset enters HUNT.

- **Reset values:** frame=0, frame_valid=0, frame_error=0, frame_abort=0, busy=0. The hunt shift register, payload register, bit counter and gap counter are all 0.
- **HUNT:**
  - Each accepted bit shifts into a PREAMBLE_BITS-wide register, entering at the LSB.
  - When the post-shift value equals PREAMBLE, the block moves to RECEIVE: bit counter=0, gap counter=0.
  - Overlapping matches are found naturally because the register slides one bit at a time.
  - Cycles with serial_valid=0 have no effect.
- **RECEIVE:**
  - Each accepted bit shifts into the payload register (P = FRAME_BITS − PREAMBLE_BITS bits), increments the bit counter and clears the gap counter.
  - Each cycle with serial_valid=0 increments the gap counter.
  - **Completion:** the edge accepting payload bit P−1 does all of the following:
    - loads frame = {PREAMBLE, payload with that final bit};
    - pulses frame_valid;
    - drives frame_error;
    - clears the hunt register;
    - returns to HUNT.
  - **Gap timeout:** if the gap counter reaches GAP_LIMIT, the block pulses frame_abort, clears the hunt register and returns to HUNT. frame is unchanged.
  - A bit accepted on the same cycle the gap counter would reach GAP_LIMIT counts as a bit, so no abort occurs.
- **frame** holds its value until the next completion; aborts and errors never modify it.
- **Re-hunt after a frame:** no bits from the completed frame are reused. The next preamble needs PREAMBLE_BITS fresh bits.
- **Reset mid-frame:** all state is discarded immediately, with no strobe.

## Timing

- frame_valid, frame, frame_error and frame_abort are registered outputs. They change on the edge that accepts the final bit or hits the timeout.
- Strobes are high for exactly one cycle.
- **Latency:** the final payload bit is sampled at edge N, and frame_valid=1 during the cycle after edge N.
- **Minimum frame-to-frame spacing:** FRAME_BITS accepted bits.
- **Back-to-back:** serial_valid=1 on every cycle is supported with no dead cycles.
- busy rises on the edge matching the preamble and falls on the completion or abort edge.

## Configuration

- **BEP_FRAME_CHECKSUM_EN defined:**
  - The payload is treated as P/8 bytes, MSB-first.
  - frame_error=1 when the mod-256 sum of all payload bytes except the last ≠ the last byte.
  - The sum is accumulated byte-by-byte during RECEIVE (8-bit adder, no full-frame adder).
- **BEP_FRAME_CHECKSUM_EN undefined:**
  - frame_error is tied to 0 and the accumulator is not built.
  - All other behaviour is identical.

## Test plan

- **Reset:** assert reset mid-RECEIVE (bit 50 of payload) → all outputs 0 immediately. After release, a full valid frame decodes correctly.
- **Nominal:** default parameters, serial_valid=1 continuously, send 32'hAAAA_AAAA then a 160-bit payload whose last byte = sum of the first 19 bytes → one frame_valid pulse exactly one cycle after the last bit; frame matches the sent 192 bits; frame_error=0.
- **Preamble search:**
  - Send 7 junk bits 1011001, then the preamble with one leading extra 1/0 pair, then the payload → frame decoded.
  - Then send 31 preamble bits followed by a wrong bit → no RECEIVE entry.
- **Gap timeout:**
  - Stall serial_valid for 63 cycles mid-payload, then continue → frame completes.
  - Stall for 64 cycles → frame_abort pulses on the 64th idle edge; frame keeps its previous value; busy=0.
- **Checksum:** corrupt the last payload byte by +1, with BEP_FRAME_CHECKSUM_EN defined → frame_valid=1, frame_error=1. Undefined → frame_error=0.
- **Throttled and parametrised:** FRAME_BITS=40, PREAMBLE_BITS=8, PREAMBLE=8'hD5, serial_valid on every third cycle → correct 40-bit frame; busy spans from the preamble match to completion.
